// File: rtl/prog_fetch.sv
// prog_fetch: instruction fetch unit for the HRM CPU.
//
// Reads 1- or 2-byte instructions from a synchronous program ROM and tracks
// the program counter. Each decoded bundle {opcode, operand, pc} is offered to
// the control unit over a valid/ready handshake. Jump redirects from the
// control unit cancel any fetch that is in flight.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   rom_en, rom_addr      ROM read strobe and address (data returns 1 cycle later)
//   rom_data              ROM read data
//   ins_valid, ins_ready  instruction bundle handshake
//   ins_opcode            opcode byte of the presented bundle
//   ins_operand           operand byte (0 for 1-byte instructions)
//   ins_pc                address of the opcode byte
//   jump_en, jump_addr    single-cycle redirect request and its target
//   halt                  suppresses new instruction fetches while high
//
// state   | meaning
// --------+---------------------------------------------------------------
// REQ_OP  | issue the opcode read at pc (held off while halt is high)
// CAP_OP  | capture the opcode; issue the operand read for a 2-byte instruction
// CAP_ARG | capture the operand byte
// VALID   | bundle presented; wait for ins_ready

module prog_fetch #(
    parameter int PROG_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   rom_en,
    output logic [PROG_ADDR_W-1:0] rom_addr,
    input  logic [7:0]             rom_data,
    output logic                   ins_valid,
    input  logic                   ins_ready,
    output logic [7:0]             ins_opcode,
    output logic [7:0]             ins_operand,
    output logic [PROG_ADDR_W-1:0] ins_pc,
    input  logic                   jump_en,
    input  logic [PROG_ADDR_W-1:0] jump_addr,
    input  logic                   halt
);

    typedef enum logic [1:0] {
        REQ_OP  = 2'd0,
        CAP_OP  = 2'd1,
        CAP_ARG = 2'd2,
        VALID   = 2'd3
    } state_t;

    localparam logic [PROG_ADDR_W-1:0] PC_ONE = {{(PROG_ADDR_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [PROG_ADDR_W-1:0] pc_q, pc_d;
    logic [PROG_ADDR_W-1:0] ins_pc_q, ins_pc_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [7:0]             operand_q, operand_d;
    logic [PROG_ADDR_W-1:0] pc_inc;
    logic                   rom_en_c;
    logic [PROG_ADDR_W-1:0] rom_addr_c;

    // Wraps modulo 2^PROG_ADDR_W, so an operand behind the last address is read from 0.
    assign pc_inc = pc_q + PC_ONE;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ins_pc_d   = ins_pc_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        rom_en_c   = 1'b0;
        rom_addr_c = pc_q;

        case (state_q)
            REQ_OP: begin
                if (!halt) begin
                    rom_en_c   = 1'b1;
                    rom_addr_c = pc_q;
                    ins_pc_d   = pc_q;
                    state_d    = CAP_OP;
                end
            end
            CAP_OP: begin
                opcode_d = rom_data;
                pc_d     = pc_inc;
                if (rom_data[7]) begin
                    rom_en_c   = 1'b1;
                    rom_addr_c = pc_inc;
                    state_d    = CAP_ARG;
                end else begin
                    operand_d = 8'h00;
                    state_d   = VALID;
                end
            end
            CAP_ARG: begin
                operand_d = rom_data;
                pc_d      = pc_inc;
                state_d   = VALID;
            end
            VALID: begin
                if (ins_ready) begin
                    state_d = REQ_OP;
                end
            end
            default: begin
                state_d = REQ_OP;
            end
        endcase

        // A redirect wins over everything: any partial capture is abandoned and
        // the bundle registers keep their old contents (ins_valid drops anyway).
        // In VALID with ins_ready high the handshake has already completed.
        if (jump_en) begin
            state_d   = REQ_OP;
            pc_d      = jump_addr;
            ins_pc_d  = ins_pc_q;
            opcode_d  = opcode_q;
            operand_d = operand_q;
            rom_en_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REQ_OP;
            pc_q      <= '0;
            ins_pc_q  <= '0;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_pc_q  <= ins_pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    // The reset state is REQ_OP, which would otherwise strobe the ROM while
    // reset is still asserted; the strobe is held low until reset releases.
    assign rom_en      = rom_en_c & rst_n;
    assign rom_addr    = rom_addr_c;
    assign ins_valid   = (state_q == VALID);
    assign ins_opcode  = opcode_q;
    assign ins_operand = operand_q;
    assign ins_pc      = ins_pc_q;

endmodule

// File: tb/tb_prog_fetch.sv
module tb_prog_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rom_en;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic       ins_valid;
    logic       ins_ready = 1'b0;
    logic [7:0] ins_opcode;
    logic [7:0] ins_operand;
    logic [7:0] ins_pc;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic       halt = 1'b0;

    logic [7:0] rom [256];

    int total = 0;
    int bad = 0;

    prog_fetch #(.PROG_ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_opcode  (ins_opcode),
        .ins_operand (ins_operand),
        .ins_pc      (ins_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    // Advance to just after the next rising edge; inputs are changed here and
    // outputs are sampled a further #1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ins_ready = 1'b0;
        halt = 1'b0;
        jump_en = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        repeat (3) tick();
        #1;
        total++;
        if ({rom_en, ins_valid, ins_opcode, ins_operand, ins_pc} !== 26'h0) begin
            bad++;
            $display("FAIL reset_outputs: rom_en=%b valid=%b op=%h arg=%h pc=%h, want all zero",
                     rom_en, ins_valid, ins_opcode, ins_operand, ins_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_one_byte();
        rom[0] = 8'h01;
        rom[1] = 8'h85;
        rom[2] = 8'h3C;
        ins_ready = 1'b1;
        #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL first_fetch: rom_en=%b addr=%h, want 1 at 00", rom_en, rom_addr);
        end
        tick(); #1;
        total++;
        if (rom_en !== 1'b0 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL one_byte_cap: rom_en=%b valid=%b, want 0 0", rom_en, ins_valid);
        end
        tick(); #1;
        total++;
        if (ins_valid !== 1'b1 || ins_opcode !== 8'h01 || ins_operand !== 8'h00 || ins_pc !== 8'h00) begin
            bad++;
            $display("FAIL one_byte_bundle: valid=%b op=%h arg=%h pc=%h, want 1 01 00 00",
                     ins_valid, ins_opcode, ins_operand, ins_pc);
        end
        tick(); #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h01 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL one_byte_next: rom_en=%b addr=%h valid=%b, want 1 01 0",
                     rom_en, rom_addr, ins_valid);
        end
    endtask

    task automatic test_two_byte();
        ins_ready = 1'b0;
        tick(); #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h02 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL operand_req: rom_en=%b addr=%h valid=%b, want 1 02 0",
                     rom_en, rom_addr, ins_valid);
        end
        tick(); #1;
        total++;
        if (rom_en !== 1'b0 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL cap_arg: rom_en=%b valid=%b, want 0 0", rom_en, ins_valid);
        end
        tick(); #1;
        total++;
        if (ins_valid !== 1'b1 || ins_opcode !== 8'h85 || ins_operand !== 8'h3C || ins_pc !== 8'h01) begin
            bad++;
            $display("FAIL two_byte_bundle: valid=%b op=%h arg=%h pc=%h, want 1 85 3c 01",
                     ins_valid, ins_opcode, ins_operand, ins_pc);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            total++;
            if (ins_valid !== 1'b1 || ins_opcode !== 8'h85 || ins_operand !== 8'h3C ||
                ins_pc !== 8'h01 || rom_en !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: valid=%b op=%h arg=%h pc=%h rom_en=%b, want 1 85 3c 01 0",
                         i, ins_valid, ins_opcode, ins_operand, ins_pc, rom_en);
            end
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h03 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_stall: rom_en=%b addr=%h valid=%b, want 1 03 0",
                     rom_en, rom_addr, ins_valid);
        end
    endtask

    task automatic test_jump();
        rom[3] = 8'hA0;
        rom[4] = 8'h11;
        rom[8'h40] = 8'h02;
        tick(); #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h04) begin
            bad++;
            $display("FAIL jump_pre_operand: rom_en=%b addr=%h, want 1 04", rom_en, rom_addr);
        end
        tick();
        jump_en = 1'b1;
        jump_addr = 8'h40;
        #1;
        total++;
        if (rom_en !== 1'b0) begin
            bad++;
            $display("FAIL jump_cap_arg_rom_en: rom_en=%b, want 0", rom_en);
        end
        tick();
        jump_en = 1'b0;
        #1;
        total++;
        if (ins_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 8'h40) begin
            bad++;
            $display("FAIL jump_redirect: valid=%b rom_en=%b addr=%h, want 0 1 40",
                     ins_valid, rom_en, rom_addr);
        end
        tick();
        tick(); #1;
        total++;
        if (ins_valid !== 1'b1 || ins_opcode !== 8'h02 || ins_operand !== 8'h00 || ins_pc !== 8'h40) begin
            bad++;
            $display("FAIL jump_target_bundle: valid=%b op=%h arg=%h pc=%h, want 1 02 00 40",
                     ins_valid, ins_opcode, ins_operand, ins_pc);
        end
        ins_ready = 1'b1;
        jump_en = 1'b1;
        jump_addr = 8'h40;
        tick();
        ins_ready = 1'b0;
        jump_en = 1'b0;
        #1;
        total++;
        if (ins_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 8'h40) begin
            bad++;
            $display("FAIL jump_with_accept: valid=%b rom_en=%b addr=%h, want 0 1 40",
                     ins_valid, rom_en, rom_addr);
        end
    endtask

    task automatic test_wrap();
        rom[8'hFF] = 8'h90;
        rom[0] = 8'h07;
        jump_en = 1'b1;
        jump_addr = 8'hFF;
        #1;
        total++;
        if (rom_en !== 1'b0) begin
            bad++;
            $display("FAIL jump_req_rom_en: rom_en=%b, want 0", rom_en);
        end
        tick();
        jump_en = 1'b0;
        #1;
        tick(); #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL wrap_operand_addr: rom_en=%b addr=%h, want 1 00", rom_en, rom_addr);
        end
        tick();
        tick(); #1;
        total++;
        if (ins_valid !== 1'b1 || ins_opcode !== 8'h90 || ins_operand !== 8'h07 || ins_pc !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_bundle: valid=%b op=%h arg=%h pc=%h, want 1 90 07 ff",
                     ins_valid, ins_opcode, ins_operand, ins_pc);
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h01) begin
            bad++;
            $display("FAIL wrap_next_pc: rom_en=%b addr=%h, want 1 01", rom_en, rom_addr);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rom_en !== 1'b0) begin
                bad++;
                $display("FAIL halt_suppress[%0d]: rom_en=%b, want 0", i, rom_en);
            end
            tick(); #1;
        end
        rom[8'hFF] = 8'h05;
        jump_en = 1'b1;
        jump_addr = 8'hFF;
        tick();
        jump_en = 1'b0;
        #1;
        total++;
        if (rom_en !== 1'b0 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_jump_wait: rom_en=%b valid=%b, want 0 0", rom_en, ins_valid);
        end
        halt = 1'b0;
        #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'hFF) begin
            bad++;
            $display("FAIL halt_resume: rom_en=%b addr=%h, want 1 ff", rom_en, rom_addr);
        end
        tick();
        tick(); #1;
        total++;
        if (ins_valid !== 1'b1 || ins_opcode !== 8'h05 || ins_operand !== 8'h00 || ins_pc !== 8'hFF) begin
            bad++;
            $display("FAIL one_byte_wrap_bundle: valid=%b op=%h arg=%h pc=%h, want 1 05 00 ff",
                     ins_valid, ins_opcode, ins_operand, ins_pc);
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL one_byte_wrap_next: rom_en=%b addr=%h, want 1 00", rom_en, rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        rom[0] = 8'h81;
        rom[1] = 8'h85;
        tick(); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rom_en, ins_valid, ins_opcode, ins_operand, ins_pc} !== 26'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: rom_en=%b valid=%b op=%h arg=%h pc=%h, want all zero",
                     rom_en, ins_valid, ins_opcode, ins_operand, ins_pc);
        end
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h00 || ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_restart: rom_en=%b addr=%h valid=%b, want 1 00 0",
                     rom_en, rom_addr, ins_valid);
        end
        tick();
        tick();
        tick(); #1;
        total++;
        if (ins_valid !== 1'b1 || ins_opcode !== 8'h81 || ins_operand !== 8'h85 || ins_pc !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_bundle: valid=%b op=%h arg=%h pc=%h, want 1 81 85 00",
                     ins_valid, ins_opcode, ins_operand, ins_pc);
        end
    endtask

    // Transaction-level reference: the next bundle to appear is always the
    // instruction at model_pc; an accept advances model_pc by the instruction
    // length, a jump overwrites it (after any accept in the same cycle).
    task automatic test_random();
        logic [7:0] model_pc;
        logic [7:0] nxt;
        logic [7:0] exp_arg;
        logic       prev_hold;
        logic       prev_jump;
        int         accepts;

        rst_n = 1'b0;
        ins_ready = 1'b0;
        halt = 1'b0;
        jump_en = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        tick();
        rst_n = 1'b1;
        model_pc = 8'h00;
        prev_hold = 1'b0;
        prev_jump = 1'b0;
        accepts = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            ins_ready = ($urandom_range(0, 2) != 0);
            halt = ($urandom_range(0, 4) == 0);
            jump_en = ($urandom_range(0, 24) == 0);
            jump_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(254, 255)) : 8'($urandom);
            #1;
            nxt = model_pc + 8'd1;
            exp_arg = rom[model_pc][7] ? rom[nxt] : 8'h00;

            if (ins_valid) begin
                total++;
                if (ins_pc !== model_pc || ins_opcode !== rom[model_pc] || ins_operand !== exp_arg) begin
                    bad++;
                    $display("FAIL rand_bundle cyc=%0d: op=%h arg=%h pc=%h, want %h %h %h",
                             cyc, ins_opcode, ins_operand, ins_pc, rom[model_pc], exp_arg, model_pc);
                end
            end
            if (prev_hold) begin
                total++;
                if (ins_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_hold cyc=%0d: valid=%b, want 1", cyc, ins_valid);
                end
            end
            if (prev_jump) begin
                total++;
                if (ins_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_after_jump cyc=%0d: valid=%b, want 0", cyc, ins_valid);
                end
            end
            if (rom_en) begin
                total++;
                if (jump_en || (rom_addr !== model_pc && rom_addr !== nxt) ||
                    (halt && rom_addr !== nxt)) begin
                    bad++;
                    $display("FAIL rand_rom_req cyc=%0d: addr=%h jump=%b halt=%b, want no read or addr %h/%h",
                             cyc, rom_addr, jump_en, halt, model_pc, nxt);
                end
            end

            if (ins_valid && ins_ready) begin
                accepts++;
                model_pc = rom[model_pc][7] ? model_pc + 8'd2 : nxt;
            end
            if (jump_en) model_pc = jump_addr;
            prev_hold = ins_valid && !ins_ready && !jump_en;
            prev_jump = jump_en;
            tick();
        end
        jump_en = 1'b0;
        halt = 1'b0;
        total++;
        if (accepts < 50) begin
            bad++;
            $display("FAIL rand_progress: accepts=%0d, want at least 50", accepts);
        end
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_two_byte();
        test_stall();
        test_jump();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
